eco32_ethernet_ptr_fifo: RTL



---
 rtl/eco32_ethernet_ptr_fifo.sv | 92 +++++++++
 1 files changed

// File: rtl/eco32_ethernet_ptr_fifo.sv
// Circular FIFO of 36-bit packet descriptors mapped onto one half of the Ethernet
// pointer buffer; push and pop share the single stb/wen/addr/data port.
module eco32_ethernet_ptr_fifo #(
    parameter int BUFF_ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push_stb,
    input  logic [35:0]                push_data,
    output logic                       push_rdy,
    input  logic                       pop_stb,
    output logic                       pop_rdy,
    output logic                       pop_o_stb,
    output logic [35:0]                pop_o_data,
    output logic                       m_stb,
    output logic                       m_wen,
    output logic [35:0]                m_data,
    output logic [BUFF_ADDR_WIDTH-2:0] m_addr,
    input  logic                       m_i_stb,
    input  logic [35:0]                m_i_data,
    output logic [BUFF_ADDR_WIDTH-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW    = BUFF_ADDR_WIDTH - 1;
    localparam int DEPTH = 1 << AW;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          prio;
    logic          push_elig;
    logic          pop_elig;
    logic          push_acc;
    logic          pop_acc;

    assign empty = (count == '0);
    assign full  = (count == BUFF_ADDR_WIDTH'(DEPTH));

    assign push_elig = push_stb && !full;
    assign pop_elig  = pop_stb && !empty;

    // Each ready only looks at the opposing strobe, so the two can never both be granted.
    assign push_rdy = !full && !flush && !(pop_elig && prio);
    assign pop_rdy  = !empty && !flush && !(push_elig && !prio);

    assign push_acc = push_stb && push_rdy;
    assign pop_acc  = pop_stb && pop_rdy;

    // Reads return in issue order, so the buffer response is forwarded untouched.
    assign pop_o_stb  = m_i_stb;
    assign pop_o_data = m_i_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            prio   <= 1'b0;
            m_stb  <= 1'b0;
            m_wen  <= 1'b0;
            m_addr <= '0;
            m_data <= '0;
        end else begin
            m_stb <= 1'b0;
            m_wen <= 1'b0;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                prio   <= 1'b0;
            end else begin
                if (push_acc) begin
                    m_stb  <= 1'b1;
                    m_wen  <= 1'b1;
                    m_addr <= wr_ptr;
                    m_data <= push_data;
                    wr_ptr <= wr_ptr + 1'b1;
                    count  <= count + 1'b1;
                end else if (pop_acc) begin
                    m_stb  <= 1'b1;
                    m_addr <= rd_ptr;
                    rd_ptr <= rd_ptr + 1'b1;
                    count  <= count - 1'b1;
                end
                // Fairness flips only when both sides were actually competing.
                if (push_elig && pop_elig)
                    prio <= !prio;
            end
        end
    end
endmodule
